// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and its receive-side benches.
package serial_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_REP_W = 4;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = serial_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // Count increments, stopping at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured word MSB first, in_reps+1 times,
// with a one-cycle IDLE gap between requests and a saturating frame counter.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_reps,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int unsigned BCW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [BCW-1:0]   bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             last_bit;

  // The captured word is never shifted; bit_cnt selects the presented bit so
  // every repetition replays identical data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word    <= in_data;
            rep_cnt <= in_reps;
            bit_cnt <= BCW'(WIDTH - 1);
            state   <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt == '0) begin
            if (rep_cnt != '0) begin
              rep_cnt <= rep_cnt - REP_W'(1);
              bit_cnt <= BCW'(WIDTH - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - BCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    last_bit = (state == SEND) && (bit_cnt == '0);
    in_ready = (state == IDLE);
    a_valid  = (state == SEND);
    busy     = (state == SEND);
    a        = (state == SEND) && word[bit_cnt];
    done     = last_bit && (rep_cnt == '0);
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (last_bit),
    .q   (sent_count)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized and directed bench for serial_pattern_tx against a bit-queue model.
module tb_serial_pattern_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [3:0]  in_reps;
  logic        in_ready, a, a_valid, busy, done;
  logic [15:0] sent_count;
  logic        in_ready_s, a_s, a_valid_s, busy_s, done_s;
  logic [1:0]  sent_count_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit b;
    bit fend;
    bit last;
  } ebit_t;

  ebit_t exp_q[$];
  int    exp_count = 0;
  logic [2:0] hist;
  int    det_matches;
  int    small_tbl[5] = '{1, 2, 3, 3, 3};

  serial_pattern_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_reps(in_reps), .a(a), .a_valid(a_valid),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  serial_pattern_tx #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_reps(in_reps), .a(a_s), .a_valid(a_valid_s),
    .busy(busy_s), .done(done_s), .sent_count(sent_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    int small_exp;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check("a", 32'(a), 32'(exp_q[0].b));
      check("a_valid", 32'(a_valid), 1);
      check("busy", 32'(busy), 1);
      check("done", 32'(done), 32'(exp_q[0].last));
      check("in_ready", 32'(in_ready), 0);
    end else begin
      check("a_idle", 32'(a), 0);
      check("a_valid_idle", 32'(a_valid), 0);
      check("busy_idle", 32'(busy), 0);
      check("done_idle", 32'(done), 0);
      check("in_ready_idle", 32'(in_ready), 1);
    end
    check("sent_count", 32'(sent_count), 32'(exp_count));
    small_exp = (exp_count > 3) ? 3 : exp_count;
    check("sent_count_small", 32'(sent_count_s), 32'(small_exp));
    if (a_valid) begin
      hist = {hist[1:0], a};
      if (hist == 3'b101) det_matches++;
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_count = 0;
    end else if (exp_q.size() > 0) begin
      if (exp_q[0].fend && exp_count < 65535) exp_count++;
      void'(exp_q.pop_front());
    end else if (in_valid) begin
      for (int r = 0; r <= int'(in_reps); r++) begin
        for (int i = 7; i >= 0; i--) begin
          ebit_t e;
          e.b    = in_data[i];
          e.fend = (i == 0);
          e.last = (i == 0) && (r == int'(in_reps));
          exp_q.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_reps  = r;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_reps = '0;
    hist = '0;
    det_matches = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Single frame, no repeats.
    send(8'b1010_0000, 4'd0);
    repeat (10) step();

    // Three repetitions of A5.
    send(8'hA5, 4'd2);
    repeat (26) step();

    // in_valid held high across two requests.
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_reps = 4'd0;
    step();
    in_data = 8'h00;
    repeat (10) step();
    in_valid = 1'b0;
    repeat (10) step();

    // Reset while bit 4 is on the line.
    do_reset();
    send(8'hC3, 4'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("abort_count", 32'(sent_count), 0);

    // Narrow counter saturation over five frames.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send(8'($urandom), 4'd0);
      repeat (8) step();
      check("small_sat_seq", 32'(sent_count_s), 32'(small_tbl[f]));
    end
    step();

    // Loopback into a 101 detector.
    do_reset();
    hist = '0;
    det_matches = 0;
    send(8'b1010_1000, 4'd0);
    repeat (10) step();
    check("det_101_matches", 32'(det_matches), 2);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 249) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 8'($urandom);
      in_reps  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (140) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
